// File: rtl/z16_pkg.sv
// Shared types and constants for the Z16 instruction fetch path.
// Optional fetch statistics in z16_instr_fetch are enabled with Z16_FETCH_STATS_EN.
package z16_pkg;

    localparam int Z16_INSTR_W = 16;
    localparam int Z16_ADDR_W  = 16;

    localparam logic [Z16_ADDR_W-1:0] Z16_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } fetch_state_e;

    // One prefetch entry: the word together with the address it came from.
    typedef struct packed {
        logic [Z16_ADDR_W-1:0]  pc;
        logic [Z16_INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [Z16_ADDR_W-1:0] next_pc(
        input logic [Z16_ADDR_W-1:0] pc,
        input logic [Z16_ADDR_W-1:0] step
    );
        return pc + step;
    endfunction

endpackage

// File: rtl/z16_fetch_fifo.sv
// Small synchronous prefetch FIFO of {pc, instr} entries with push, pop and flush.
// Flush wins over push and pop; the head entry is read combinationally from registers.
module z16_fetch_fifo
    import z16_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [31:0]      push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [31:0]      head_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_eff;
    logic             push_eff;

    always_comb begin
        pop_eff  = pop & (count_q != '0);
        // A full FIFO still accepts a push when the same cycle pops.
        push_eff = push & ((count_q != DEPTH_C) | pop_eff);

        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_eff) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push_eff) - CNT_W'(pop_eff);
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else begin
                    mem_q[gi] <= mem_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/z16_instr_fetch.sv
// Z16 instruction fetch: PC, single-outstanding imem req/ack, prefetch FIFO, jump redirect.
// Define Z16_FETCH_STATS_EN to add the o_fetch_cnt / o_flush_cnt statistics outputs.
module z16_instr_fetch
    import z16_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = Z16_RESET_PC,
    parameter int          PC_STEP    = 2,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    output logic                   o_imem_req,
    output logic [Z16_ADDR_W-1:0]  o_imem_addr,
    input  logic                   i_imem_ack,
    input  logic [Z16_INSTR_W-1:0] i_imem_rdata,
    input  logic                   i_jump_en,
    input  logic [Z16_ADDR_W-1:0]  i_jump_addr,
    output logic [Z16_INSTR_W-1:0] o_instr,
    output logic [Z16_ADDR_W-1:0]  o_instr_pc,
    output logic                   o_instr_valid,
`ifdef Z16_FETCH_STATS_EN
    output logic [15:0]            o_fetch_cnt,
    output logic [15:0]            o_flush_cnt,
`endif
    input  logic                   i_instr_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0]          DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [Z16_ADDR_W-1:0]   STEP_C  = Z16_ADDR_W'(PC_STEP);

    fetch_state_e            state_q, state_d;
    logic [Z16_ADDR_W-1:0]   pc_q, pc_d;
    logic                    req_q, req_d;
    logic [Z16_ADDR_W-1:0]   addr_q, addr_d;

    logic                    ack;
    logic                    pop;
    logic                    push;
    logic [CNT_W-1:0]        fifo_count;
    logic [CNT_W:0]          count_next;
    logic                    credit;
    logic [Z16_ADDR_W-1:0]   pc_after_ack;
    fetch_entry_t            push_entry;
    fetch_entry_t            head_entry;
    logic [31:0]             fifo_head;

    assign o_instr_valid = (fifo_count != '0);

    always_comb begin
        ack          = req_q & i_imem_ack;
        pop          = o_instr_valid & i_instr_ready & ~i_jump_en;
        // Only a live S_WAIT response is kept; jump-cycle and discard acks are dropped.
        push         = (state_q == S_WAIT) & ack & ~i_jump_en;
        pc_after_ack = next_pc(addr_q, STEP_C);

        push_entry.pc    = addr_q;
        push_entry.instr = i_imem_rdata;

        if (i_jump_en) begin
            count_next = '0;
        end else begin
            count_next = {1'b0, fifo_count} + (CNT_W + 1)'(push) - (CNT_W + 1)'(pop);
        end
        credit = (count_next < DEPTH_C);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;

        if (i_jump_en) begin
            pc_d = i_jump_addr;
            if (state_q == S_IDLE) begin
                state_d = S_WAIT;
                req_d   = 1'b1;
                addr_d  = i_jump_addr;
            end else if (ack) begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end else begin
                // The in-flight request must still complete with a stable address.
                state_d = S_DISCARD;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (credit) begin
                        state_d = S_WAIT;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                    end
                end
                S_WAIT: begin
                    if (ack) begin
                        pc_d = pc_after_ack;
                        if (credit) begin
                            addr_d = pc_after_ack;
                        end else begin
                            state_d = S_IDLE;
                            req_d   = 1'b0;
                        end
                    end
                end
                S_DISCARD: begin
                    if (ack) begin
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    z16_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .flush     (i_jump_en),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .count     (fifo_count),
        .head_data (fifo_head)
    );

    assign head_entry  = fetch_entry_t'(fifo_head);
    assign o_instr     = head_entry.instr;
    assign o_instr_pc  = head_entry.pc;
    assign o_imem_req  = req_q;
    assign o_imem_addr = addr_q;

`ifdef Z16_FETCH_STATS_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 16'(push);
        flush_cnt_d = flush_cnt_q + 16'(i_jump_en);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_fetch_cnt = fetch_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/z16_instr_fetch.md
Name: z16_instr_fetch

Overview:
- Instruction fetch unit for the Z16 core. It is the producer side of the 16-bit instruction word consumed by the instruction decoder.
- Holds the PC and requests words from instruction memory over a req/ack handshake. Buffers fetched words in a small prefetch FIFO and presents them to the decode stage with valid/ready.
- Flushes and redirects on jump/branch requests from execute.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_STEP, 2, address increment per fetched instruction (byte-addressed, 16-bit instructions).
- FIFO_DEPTH, 2, prefetch entries; power of two, minimum 2.

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_rst  input  1  reset, asynchronous, active-high
- o_imem_req  output  1  memory read request (registered)
- o_imem_addr  output  16  memory read address (registered)
- i_imem_ack  input  1  read data valid; sampled only while o_imem_req=1
- i_imem_rdata  input  16  read data, valid with i_imem_ack
- i_jump_en  input  1  redirect request, single-cycle pulse
- i_jump_addr  input  16  redirect target
- o_instr  output  16  instruction word at FIFO head (to decoder i_instr)
- o_instr_pc  output  16  PC of o_instr
- o_instr_valid  output  1  FIFO non-empty
- i_instr_ready  input  1  decode accepts; pop when valid&ready

Behaviour:
- Reset values:
  - pc=RESET_PC; FIFO empty; state=S_IDLE.
  - o_imem_req=0; o_imem_addr=RESET_PC.
  - o_instr_valid=0; o_instr=16'h0000; o_instr_pc=16'h0000.
- Reset mid-transaction drops the outstanding request. A late ack after reset deasserts is ignored because req=0.
- Outstanding requests: at most one.
- FSM states:
  - S_IDLE: no request outstanding. If credit is available, go to S_WAIT next cycle with o_imem_req=1 and o_imem_addr=pc.
    - Credit: count_next < FIFO_DEPTH, where count_next is the FIFO count after this cycle's push/pop.
  - S_WAIT: o_imem_req held at 1 and o_imem_addr held stable until i_imem_ack.
    - On ack: push {rdata, addr} and set pc=addr+PC_STEP (16-bit wrap, 16'hFFFE+2=16'h0000).
    - If credit remains after push/pop, stay in S_WAIT with addr=new pc (back-to-back, one word per cycle). Otherwise go to S_IDLE with req=0.
  - S_DISCARD: entered when a jump occurs while a request is outstanding and not acked that cycle. o_imem_req stays 1 and the address stays stable, as the memory protocol requires.
    - On ack: data is dropped; go to S_IDLE.
- Jump (i_jump_en=1), which has priority over everything else:
  - FIFO cleared; any same-cycle pop and push are discarded; pc=i_jump_addr.
  - From S_IDLE: the next cycle issues a request to i_jump_addr.
  - From S_WAIT with same-cycle ack: data is dropped; go to S_IDLE.
  - From S_WAIT without ack: go to S_DISCARD.
  - From S_DISCARD: stay in S_DISCARD, with pc updated to the newest target.
  - o_instr_valid=0 the cycle after the jump.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Fetch latency: first instruction valid ≥2 cycles after reset release (request cycle, then ack, then push visible next cycle). With zero-wait memory (ack in the first req cycle), throughput is 1 instruction/cycle while the decoder is ready.
- o_instr and o_instr_pc change only on pop, push-into-empty, or flush. They hold their value when valid=0.

Optional Feature:
- Macro: Z16_FETCH_STATS_EN.
- Defined:
  - Adds outputs o_fetch_cnt[15:0] (increments per pushed instruction) and o_flush_cnt[15:0] (increments per i_jump_en cycle).
  - Both counters reset to 0 and wrap at 16'hFFFF→0.
  - Dropped S_DISCARD/jump-cycle acks do not count as fetches.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package z16_pkg:
  - FSM state encoding (S_IDLE, S_WAIT, S_DISCARD).
  - Z16_INSTR_W=16 and Z16_ADDR_W=16.
  - Default reset PC constant.
- Natural sub-module z16_fetch_fifo:
  - Parameterized synchronous FIFO with push, pop and flush.
  - Flush has priority; count output used for credit; 32-bit entry {pc, instr}.

Test Plan:
- Reset then zero-wait memory returning rdata=addr^16'hA5A5, ready=1:
  - Requests addr 0,2,4,… back-to-back.
  - o_instr sequence 16'hA5A5, 16'hA5A7, 16'hA5A1 with o_instr_pc 0,2,4.
- ready=0 with zero-wait memory:
  - Exactly FIFO_DEPTH=2 pushes, then req drops; valid stays 1 with instr of pc 0.
  - Raising ready resumes fetch at addr 4.
- Jump to 16'h0100 while a req to 16'h0006 is pending (ack 3 cycles later):
  - req/addr hold 16'h0006 until ack; that data is never presented.
  - Next request is addr 16'h0100; first valid instr has o_instr_pc=16'h0100.
- Jump coinciding with ack and pop in the same cycle:
  - FIFO empty next cycle; ack data is dropped.
  - Next request is to the jump target; with STATS, fetch_cnt is unchanged and flush_cnt increments by 1.
- PC wrap:
  - Jump to 16'hFFFE, then fetch two words.
  - o_instr_pc = 16'hFFFE then 16'h0000.
- Async reset asserted mid-S_WAIT, between clock edges:
  - o_imem_req=0 and o_instr_valid=0 immediately.
  - After release, the first request is addr RESET_PC.
